// File: rtl/config_chain.sv
// config_chain: double-buffered serial configuration store with MSB-first readback.
// Bits shift into a shadow register; the active config updates only on an exact-length frame.
module config_chain #(
    parameter int NUM_FIELDS  = 3,
    parameter int FIELD_WIDTH = 6,
    parameter logic [NUM_FIELDS*FIELD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              serialEn,
    input  logic                              serialIn,
    output logic                              serialOut,
    output logic [NUM_FIELDS*FIELD_WIDTH-1:0] configOut,
    output logic                              commitPulse,
    output logic                              frameError
);
    localparam int TOTAL = NUM_FIELDS * FIELD_WIDTH;
    localparam int CW    = $clog2(TOTAL + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, END_F} state_e;

    logic [TOTAL-1:0] shadow_q, shadow_d, cfg_q, cfg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             en_prev_q, commit_q, commit_d, err_q, err_d;
    state_e           st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q  <= RESET_VALUE;
            cfg_q     <= RESET_VALUE;
            cnt_q     <= '0;
            en_prev_q <= 1'b0;
            commit_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            cfg_q     <= cfg_d;
            cnt_q     <= cnt_d;
            en_prev_q <= serialEn;
            commit_q  <= commit_d;
            err_q     <= err_d;
        end
    end

    // Frame state is decoded from the live enable and its registered copy.
    always_comb begin
        st       = serialEn ? SHIFT : (en_prev_q ? END_F : IDLE);
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        cfg_d    = cfg_q;
        commit_d = 1'b0;
        err_d    = err_q;
        case (st)
            SHIFT: begin
                shadow_d = {shadow_q[TOTAL-2:0], serialIn};
                // Saturate so very long frames can never wrap back to an exact count.
                cnt_d    = (cnt_q == CW'(TOTAL + 1)) ? cnt_q : cnt_q + 1'b1;
            end
            END_F: begin
                cnt_d    = '0;
                commit_d = (cnt_q == CW'(TOTAL));
                cfg_d    = commit_d ? shadow_q : cfg_q;
                err_d    = !commit_d;
            end
            default: begin
                shadow_d = cfg_q;
                cnt_d    = '0;
            end
        endcase
    end

    assign serialOut   = shadow_q[TOTAL-1];
    assign configOut   = cfg_q;
    assign commitPulse = commit_q;
    assign frameError  = err_q;
endmodule

// File: tb/tb_config_chain.sv
// tb_config_chain: scoreboard bench for config_chain (3x6-bit fields, reset value 0).
// Readback bits are queued as each bit is driven and compared against serialOut.
module tb_config_chain;
    localparam int TOTAL = 18;

    logic             clk = 1'b0;
    logic             reset, serialEn, serialIn, serialOut, commitPulse, frameError;
    logic [TOTAL-1:0] configOut;

    logic [TOTAL-1:0] exp_cfg;
    logic [TOTAL-1:0] rb_word;
    logic             rb_q[$];
    int               n_chk = 0;
    int               n_pass = 0;

    config_chain dut (
        .clk(clk), .reset(reset), .serialEn(serialEn), .serialIn(serialIn),
        .serialOut(serialOut), .configOut(configOut),
        .commitPulse(commitPulse), .frameError(frameError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serialEn = 1'b0;
        serialIn = 1'b0;
        repeat (n) tick();
    endtask

    // Drives n bits MSB-first; before each shift edge serialOut must show the old
    // config for the first TOTAL bits, then the bits of this frame passing through.
    task automatic shift_bits(input logic [299:0] data, input int n);
        for (int k = 0; k < n; k++) begin
            serialEn = 1'b1;
            serialIn = data[n-1-k];
            rb_q.push_back(k < TOTAL ? exp_cfg[TOTAL-1-k] : data[n-1-(k-TOTAL)]);
            rb_word = {rb_word[TOTAL-2:0], serialOut};
            check("readback", 32'(serialOut), 32'(rb_q.pop_front()));
            tick();
        end
    endtask

    task automatic frame(input logic [299:0] data, input int n);
        logic ok;
        ok = (n == TOTAL);
        shift_bits(data, n);
        idle(1);
        if (ok) exp_cfg = data[TOTAL-1:0];
        check("cfg_after_frame", 32'(configOut), 32'(exp_cfg));
        check("commit_pulse", 32'(commitPulse), 32'(ok));
        check("frame_error", 32'(frameError), 32'(!ok));
        idle(1);
        check("commit_clear", 32'(commitPulse), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [299:0] big;
        exp_cfg  = '0;
        rb_word  = '0;
        reset    = 1'b1;
        serialEn = 1'b0;
        serialIn = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        idle(2);
        check("rst_cfg", 32'(configOut), 32'h0);
        check("rst_sout", 32'(serialOut), 32'h0);
        check("rst_commit", 32'(commitPulse), 32'h0);
        check("rst_err", 32'(frameError), 32'h0);

        frame(300'h2A5C3, TOTAL);
        check("field0", 32'(configOut[0 +: 6]), 32'h03);
        check("field1", 32'(configOut[6 +: 6]), 32'h17);
        check("field2", 32'(configOut[12 +: 6]), 32'h2A);

        idle(2);
        frame(300'h15A3C, TOTAL);
        check("recovered", 32'(rb_word), 32'h2A5C3);
        check("cfg_15a3c", 32'(configOut), 32'h15A3C);

        idle(2);
        frame(300'h3FF, 10);
        check("short_keeps_cfg", 32'(configOut), 32'h15A3C);
        idle(2);
        frame(300'h0F0F1, TOTAL);
        check("err_cleared", 32'(frameError), 32'h0);

        idle(2);
        frame(300'hABCDE, 20);
        check("long_keeps_cfg", 32'(configOut), 32'h0F0F1);
        idle(2);
        for (int i = 0; i < 300; i++) big[i] = 1'($urandom_range(0, 1));
        frame(big, 300);
        check("huge_keeps_cfg", 32'(configOut), 32'h0F0F1);

        idle(2);
        shift_bits(300'h1B5, 9);
        reset    = 1'b1;
        serialEn = 1'b0;
        #1;
        exp_cfg = '0;
        check("async_rst_cfg", 32'(configOut), 32'h0);
        check("async_rst_err", 32'(frameError), 32'h0);
        check("async_rst_commit", 32'(commitPulse), 32'h0);
        tick();
        reset = 1'b0;
        idle(2);
        frame(300'h3C0F5, TOTAL);
        check("post_rst_cfg", 32'(configOut), 32'h3C0F5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
